tex_arbiter: RTL and testbench
==============================

TEX_ARBITER -- requirements
Module: tex_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of secondary read clients (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 22, meaning texture word address width.
REQ-003 SHALL have parameter COLOR_WIDTH, default 12, meaning texel width (RGB444).
REQ-004 SHALL have parameter MAX_BURST, default 8, meaning maximum consecutive grants one locked client may hold.
REQ-005 SHALL have ports clk (input, 1) and rst (input, 1); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port scan_req, input, 1, meaning the scanout texel fetch is valid this cycle.
REQ-007 SHALL have port scan_addr, input, ADDR_WIDTH, meaning the scanout texel address.
REQ-008 SHALL have port scan_rvalid, output, 1, meaning scan_color is valid (the scanout request from one cycle earlier).
REQ-009 SHALL have port scan_color, output, COLOR_WIDTH, meaning the scanout texel.
REQ-010 SHALL have port req_valid, input, NUM_REQ, meaning the per-client request is valid.
REQ-011 SHALL have port req_lock, input, NUM_REQ, meaning the client requests burst ownership.
REQ-012 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH, meaning the per-client address (client i at slice i).
REQ-013 SHALL have port req_ready, output, NUM_REQ, meaning the client request is accepted this cycle.
REQ-014 SHALL have port rsp_valid, output, NUM_REQ, meaning one-hot response valid.
REQ-015 SHALL have port rsp_color, output, COLOR_WIDTH, meaning the response texel (shared by all clients).
REQ-016 SHALL have port ram_raddr, output, ADDR_WIDTH, meaning the texture RAM read address.
REQ-017 SHALL have port ram_rcolor, input, COLOR_WIDTH, meaning the RAM read data, one cycle after ram_raddr.
REQ-018 SHALL have port stall_cnt, output, 16, meaning the count of client-cycles lost to scanout priority.

Function
REQ-019 SHALL grant scan_req unconditionally in the same cycle; ram_raddr = scan_addr when scan_req=1.
REQ-020 SHALL, when scan_req=0, grant at most one client chosen round-robin starting at rr_ptr+1 (mod NUM_REQ).
REQ-021 SHALL assert req_ready[i] combinationally only in the cycle client i is granted; the transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-022 SHALL update rr_ptr to the granted index on each client transfer; rr_ptr is unchanged in cycles with no client grant.
REQ-023 SHALL register the grant tag (scan or client index) and return ram_rcolor exactly 1 cycle later: scan_rvalid or rsp_valid[idx] for one cycle.
REQ-024 SHALL implement FSM states ARB and LOCKED; ARB->LOCKED on a client transfer with req_lock=1, capturing owner and setting burst_cnt=1.
REQ-025 SHALL, in LOCKED, grant only the owner (scan still preempts); burst_cnt increments per owner transfer.
REQ-026 SHALL leave LOCKED->ARB when the owner drops req_lock, deasserts req_valid, or burst_cnt reaches MAX_BURST; rr_ptr = owner on exit.
REQ-027 SHALL increment stall_cnt by 1 per cycle in which scan_req=1 and any req_valid=1, saturating at 16'hFFFF.
REQ-028 SHALL drive ram_raddr = 0 when nothing is granted.
REQ-029 SHALL NOT let scan preemption in LOCKED count toward burst_cnt nor release the lock.

Reset
REQ-030 SHALL, while rst=0, force FSM=ARB, rr_ptr=NUM_REQ-1, burst_cnt=0, stall_cnt=0, scan_rvalid=0, rsp_valid=0, scan_color=0, rsp_color=0.
REQ-031 SHALL drop any in-flight response on reset assertion mid-burst; no rsp_valid in the first cycle after release.

Structure
REQ-032 SHALL place COLOR_WIDTH, the FSM state enum, and the grant-tag typedef in shared package gpu_pkg.
REQ-033 SHALL use one sub-module, rr_arbiter (NUM_REQ-wide rotating-priority one-hot picker); all other logic is flat.

Verification
REQ-034 SHALL cover: scan_req=1 addr 0x040 with req_valid=4'b1111 -> ram_raddr=0x040, req_ready=0, scan_rvalid next cycle, stall_cnt=1.
REQ-035 SHALL cover: scan_req=0, req_valid=4'b1111 held 8 cycles after reset -> grants 0,1,2,3,0,1,2,3.
REQ-036 SHALL cover: client 2 with req_lock=1 and MAX_BURST=8 while others request -> exactly 8 consecutive grants to client 2, then client 3.
REQ-037 SHALL cover: LOCKED owner 1 with scan_req pulsed on burst cycle 3 -> scan served, burst resumes, total 8 owner grants.
REQ-038 SHALL cover: rst asserted the cycle after a client grant -> no rsp_valid, stall_cnt=0, next grant to client 0.
REQ-039 SHALL cover: stall_cnt preset by 65540 conflicting cycles -> reads 16'hFFFF.

Source files
------------

// File: rtl/gpu_pkg.sv
// Types and constants shared by the texture-path blocks: texel width,
// arbiter FSM states and the registered grant tag.
package gpu_pkg;

  localparam int COLOR_WIDTH = 12;
  localparam int IDX_W       = 3;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             scan;
    logic             client;
    logic [IDX_W-1:0] idx;
  } grant_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot picker: the search starts at ptr+1 and wraps
// modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [gpu_pkg::IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [gpu_pkg::IDX_W-1:0] idx,
  output logic                      any
);
  import gpu_pkg::*;

  // Walk the ring once; the first requester after ptr wins.
  always_comb begin
    int   c;
    logic hit;
    gnt = {NUM_REQ{1'b0}};
    idx = {IDX_W{1'b0}};
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c      = (int'(ptr) + k) % NUM_REQ;
      hit    = !any && req[c];
      gnt[c] = hit;
      idx    = hit ? IDX_W'(c) : idx;
      any    = any | hit;
    end
  end

endmodule

// File: rtl/tex_arbiter.sv
// Texture RAM read arbiter: scanout always wins, secondary clients share the
// remaining cycles round-robin, with optional bounded burst locking.
module tex_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 22,
  parameter int COLOR_WIDTH = gpu_pkg::COLOR_WIDTH,
  parameter int MAX_BURST   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scan_req,
  input  logic [ADDR_WIDTH-1:0]         scan_addr,
  output logic                          scan_rvalid,
  output logic [COLOR_WIDTH-1:0]        scan_color,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [COLOR_WIDTH-1:0]        rsp_color,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  input  logic [COLOR_WIDTH-1:0]        ram_rcolor,
  output logic [15:0]                   stall_cnt
);
  import gpu_pkg::*;

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [BW-1:0]      burst_cnt;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               locked_eff;
  logic               xfer;
  grant_tag_t         tag;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (mask),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // The lock only holds while the owner keeps valid+lock and has burst budget
  // left; otherwise this cycle already arbitrates normally from rr_ptr.
  always_comb begin
    owner_oh   = NUM_REQ'(1) << owner;
    locked_eff = (state == LOCKED) && (|(req_valid & req_lock & owner_oh))
                 && (burst_cnt < BW'(MAX_BURST));
    mask       = locked_eff ? (req_valid & owner_oh) : req_valid;
    xfer       = !scan_req && gnt_any;
    req_ready  = xfer ? gnt : {NUM_REQ{1'b0}};
    if (scan_req) begin
      ram_raddr = scan_addr;
    end else if (gnt_any) begin
      ram_raddr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      ram_raddr = {ADDR_WIDTH{1'b0}};
    end
    tag.scan   = scan_req;
    tag.client = xfer;
    tag.idx    = gnt_idx;
  end

  // RAM data lands in the response cycle, so it is gated by the registered valids.
  always_comb begin
    if (scan_rvalid) begin
      scan_color = ram_rcolor;
    end else begin
      scan_color = {COLOR_WIDTH{1'b0}};
    end
    if (|rsp_valid) begin
      rsp_color = ram_rcolor;
    end else begin
      rsp_color = {COLOR_WIDTH{1'b0}};
    end
  end

  // Arbitration FSM, response tags and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      owner       <= {IDX_W{1'b0}};
      burst_cnt   <= {BW{1'b0}};
      stall_cnt   <= 16'h0000;
      scan_rvalid <= 1'b0;
      rsp_valid   <= {NUM_REQ{1'b0}};
    end else begin
      scan_rvalid <= tag.scan;
      rsp_valid   <= tag.client ? (NUM_REQ'(1) << tag.idx) : {NUM_REQ{1'b0}};
      if (scan_req && (|req_valid) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (xfer) begin
        rr_ptr <= gnt_idx;
      end
      // Scan cycles inside a lock leave burst_cnt and ownership untouched.
      if (locked_eff) begin
        state <= LOCKED;
        if (xfer) begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end else if (xfer && (|(req_lock & gnt))) begin
        state     <= LOCKED;
        owner     <= gnt_idx;
        burst_cnt <= BW'(1);
      end else begin
        state     <= ARB;
        burst_cnt <= {BW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_tex_arbiter.sv
// Directed bench for tex_arbiter with a one-cycle-latency RAM model whose
// data is a fixed function of the address.
module tb_tex_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_req;
  logic [21:0] scan_addr;
  logic        scan_rvalid;
  logic [11:0] scan_color;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [87:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_color;
  logic [21:0] ram_raddr;
  logic [11:0] ram_rcolor = 12'h000;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  tex_arbiter dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_rvalid(scan_rvalid), .scan_color(scan_color),
    .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_color(rsp_color),
    .ram_raddr(ram_raddr), .ram_rcolor(ram_rcolor), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] texel(input logic [21:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction

  always @(posedge clk) ram_rcolor <= texel(ram_raddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: g = -1 no grant, 4 = scan, 0..3 = client index.
  task automatic cyc(input logic s, input logic [3:0] v, input logic [3:0] l, input int g);
    logic [3:0]  exp_ready;
    logic [21:0] exp_addr;
    @(negedge clk);
    scan_req  = s;
    scan_addr = 22'h000040;
    req_valid = v;
    req_lock  = l;
    exp_ready = (g >= 0 && g < 4) ? 4'(4'b0001 << g) : 4'b0000;
    exp_addr  = (g == 4) ? 22'h000040 : (g >= 0) ? 22'(22'h000100 + g) : 22'h000000;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("ram_raddr", 32'(ram_raddr), 32'(exp_addr));
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_ready));
    chk("scan_rvalid", 32'(scan_rvalid), 32'(g == 4));
    if (g == 4) chk("scan_color", 32'(scan_color), 32'(texel(exp_addr)));
    else if (g >= 0) chk("rsp_color", 32'(rsp_color), 32'(texel(exp_addr)));
    else chk("rsp_color_idle", 32'(rsp_color), 32'h0);
  endtask

  initial begin
    rst       = 1'b0;
    scan_req  = 1'b0;
    scan_addr = 22'h000000;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    for (int i = 0; i < 4; i++) req_addr[i*22 +: 22] = 22'(22'h000100 + i);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_scan_rvalid", 32'(scan_rvalid), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_scan_color", 32'(scan_color), 32'h0);
    chk("rst_raddr", 32'(ram_raddr), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Scan preempts all four clients
    cyc(1'b1, 4'b1111, 4'b0000, 4);
    chk("stall_after_scan", 32'(stall_cnt), 32'd1);

    // Plain round-robin 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) cyc(1'b0, 4'b1111, 4'b0000, k % 4);

    // Client 2 burst: 0,1 then eight grants to 2, then 3
    cyc(1'b0, 4'b1111, 4'b0100, 0);
    cyc(1'b0, 4'b1111, 4'b0100, 1);
    for (int k = 0; k < 8; k++) cyc(1'b0, 4'b1111, 4'b0100, 2);
    cyc(1'b0, 4'b1111, 4'b0100, 3);

    // Client 1 burst with a scan pulse on burst cycle 3
    cyc(1'b0, 4'b1111, 4'b0010, 0);
    cyc(1'b0, 4'b1111, 4'b0010, 1);
    cyc(1'b0, 4'b1111, 4'b0010, 1);
    cyc(1'b1, 4'b1111, 4'b0010, 4);
    chk("stall_in_burst", 32'(stall_cnt), 32'd2);
    for (int k = 0; k < 6; k++) cyc(1'b0, 4'b1111, 4'b0010, 1);
    cyc(1'b0, 4'b1111, 4'b0010, 2);

    // Idle cycle drives address zero
    cyc(1'b0, 4'b0000, 4'b0000, -1);

    // Reset the cycle after a grant
    cyc(1'b0, 4'b1111, 4'b0000, 3);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    cyc(1'b0, 4'b1111, 4'b0000, 0);

    // Stall counter saturation
    @(negedge clk);
    scan_req  = 1'b1;
    req_valid = 4'b1111;
    repeat (65534) @(posedge clk);
    #1;
    chk("stall_fffe", 32'(stall_cnt), 32'h0000FFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
